rib_uart_tx: RTL and testbench

- Memory-mapped UART transmitter and a responder on the RIB peripheral bus.
- Answers the core's ex-stage load/store requests (address, write data, req, we).
- Buffers bytes in a small FIFO and serialises them 8N1, LSB first, on tx_o.
- Drives a level interrupt into the core's int_i vector when transmission drains.

---
 rtl/rib_uart_tx.sv | 251 +++++++++++++++++++++++++
 tb/tb_rib_uart_tx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rib_uart_tx.sv
// rtl/rib_uart_tx.sv - memory-mapped 8N1 UART transmitter on the RIB peripheral bus
//
// Purpose: buffers bytes written to TXDATA in a small FIFO and serialises them
// LSB first on tx_o. Raises a level interrupt when the transmitter has drained.
//
// Ports:
//   clk     core clock
//   rst     asynchronous active-high reset
//   req_i   bus access valid this cycle
//   we_i    1 = write, 0 = read
//   addr_i  byte address, only [3:2] decoded (0 CTRL, 1 STATUS, 2 BAUD_DIV, 3 TXDATA)
//   data_i  write data
//   data_o  read data, combinational from addr_i, 0 when req_i = 0
//   tx_o    serial line, idle high, registered
//   irq_o   level interrupt, registered
//
// Optional feature macro: RIB_UART_TX_PARITY_EN (CTRL[2] parity_en, CTRL[3] odd).

module rib_uart_tx #(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
`ifdef RIB_UART_TX_PARITY_EN
    localparam int CTRL_W = 4;
`else
    localparam int CTRL_W = 2;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef RIB_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    logic [CTRL_W-1:0] ctrl_q;
    logic [15:0]       baud_q;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_q, bit_d;
    logic              tx_q, tx_d;
    logic              irq_q, irq_d;
`ifdef RIB_UART_TX_PARITY_EN
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
`endif

    logic [1:0] sel;
    logic       wr, push, pop, push_ok, ovf_set, full, empty, busy;
    logic [7:0] count8;

    assign sel     = addr_i[3:2];
    assign wr      = req_i & we_i;
    assign push    = wr & (sel == 2'd3);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign busy    = (state_q != S_IDLE);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push & (~full | pop);
    assign ovf_set = push & full & ~pop;
    assign count8  = {{(8 - CW){1'b0}}, count_q};
    assign count_d = count_q + CW'(push_ok) - CW'(pop);
    // A set in the same cycle as a clear wins.
    assign ovf_d   = (ovf_q & ~(wr & (sel == 2'd1) & data_i[3])) | ovf_set;
    assign irq_d   = ctrl_q[1] & empty & (state_q == S_IDLE) & ~push;

    logic unused_bits;
    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:16]};

    // Register read mux.
    always_comb begin
        data_o = '0;
        if (req_i) begin
            case (sel)
                2'd0:    data_o[CTRL_W-1:0] = ctrl_q;
                2'd1:    data_o[15:0] = {count8, 4'b0, ovf_q, empty, full, busy};
                2'd2:    data_o[15:0] = baud_q;
                default: data_o = '0;
            endcase
        end
    end

    // Register file and FIFO bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= '0;
            baud_q  <= BAUD_DIV_RST;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr && sel == 2'd0) begin
                ctrl_q <= data_i[CTRL_W-1:0];
            end
            if (wr && sel == 2'd2) begin
                baud_q <= (data_i[15:0] == 16'd0) ? 16'd1 : data_i[15:0];
            end
            if (push_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage needs no reset; the count guards every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= data_i[7:0];
        end
    end

    // Transmit FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_q     <= '0;
            tx_q      <= 1'b1;
            irq_q     <= 1'b0;
`ifdef RIB_UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
`ifdef RIB_UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
`endif
        end
    end

    // Next state. The baud counter reloads from baud_q at each bit boundary, so a
    // BAUD_DIV write mid-frame applies from the next bit on.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        pop       = 1'b0;
`ifdef RIB_UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ctrl_q[0] && !empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    cnt_d   = baud_q - 16'd1;
                    bit_d   = 3'd0;
                    state_d = S_START;
`ifdef RIB_UART_TX_PARITY_EN
                    // Parity mode and bit are frozen for the whole frame.
                    par_en_d  = ctrl_q[2];
                    par_bit_d = (^mem_q[rptr_q]) ^ ctrl_q[3];
`endif
                end
            end
            S_START: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = baud_q - 16'd1;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = baud_q - 16'd1;
                    if (bit_q == 3'd7) begin
`ifdef RIB_UART_TX_PARITY_EN
                        state_d = par_en_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef RIB_UART_TX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = baud_q - 16'd1;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level follows the state being entered so tx_o changes with the state.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef RIB_UART_TX_PARITY_EN
            S_PARITY: tx_d = par_bit_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx_o  = tx_q;
    assign irq_o = irq_q;

endmodule

// File: tb/tb_rib_uart_tx.sv
// tb/tb_rib_uart_tx.sv - self-checking bench for rib_uart_tx
module tb_rib_uart_tx;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rib_uart_tx #(.FIFO_DEPTH(DEPTH), .BAUD_DIV_RST(16'd434)) dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req),
        .we_i   (we),
        .addr_i (addr),
        .data_i (wdata),
        .data_o (rdata),
        .tx_o   (tx),
        .irq_o  (irq)
    );

    // Reference: line level t cycles into a frame of byte b at bd clocks per bit.
    function automatic logic line_at(input logic [7:0] b, input int bd, input int t,
                                     input bit par, input bit odd);
        int idx;
        idx = t / bd;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (par && idx == 9) return (^b) ^ odd;
        return 1'b1;
    endfunction

    function automatic logic [31:0] status_word(input int cnt, input bit ovf, input bit busy);
        return (cnt << 8) | (ovf << 3) | ((cnt == 0) << 2) | ((cnt == DEPTH) << 1) | busy;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a;
        #1;
        d = rdata;
        req = 1'b0; addr = '0;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp_ctrl;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        rst = 1'b0;
        step();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL post_reset_tx: got %b expected 1", tx); end
        rd(32'h0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", d); end
        rd(32'h8, d);
        checks++; if (d !== 32'h1B2) begin errors++; $display("FAIL reset_baud: got %h expected 1b2", d); end
        rd(32'h4, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL reset_status: got %h expected 4", d); end
        rd(32'hC, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h expected 0", d); end
        addr = 32'h8; req = 1'b0; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL idle_bus_read: got %h expected 0", rdata); end
        addr = '0;
`ifdef RIB_UART_TX_PARITY_EN
        exp_ctrl = 32'hC;
`else
        exp_ctrl = 32'h0;
`endif
        wr(32'h0, 32'hC);
        rd(32'h0, d);
        checks++; if (d !== exp_ctrl) begin errors++; $display("FAIL ctrl_upper_bits: got %h expected %h", d, exp_ctrl); end
        wr(32'h0, 32'h0);
    endtask

    task automatic test_single_frame();
        logic [31:0] d;
        wr(32'h8, 32'd4);
        wr(32'h0, 32'h1);
        wr(32'hC, 32'hA5);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL a5_write_edge: got %b expected 1", tx); end
        for (int t = 0; t < 40; t++) begin
            step();
            checks++; if (tx !== line_at(8'hA5, 4, t, 0, 0)) begin errors++; $display("FAIL a5_line t=%0d: got %b expected %b", t, tx, line_at(8'hA5, 4, t, 0, 0)); end
            rd(32'h4, d);
            checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL a5_busy t=%0d: got %b expected 1", t, d[0]); end
        end
        step();
        rd(32'h4, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL a5_idle_status: got %h expected 4", d); end
        wr(32'h0, 32'h0);
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [7:0]  q[$];
        logic [7:0]  b;
        int          k, t;
        logic        e;
        wr(32'h0, 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            wr(32'hC, {24'h0, b});
            if (i < DEPTH) q.push_back(b);
        end
        rd(32'h4, d);
        checks++; if (d !== status_word(DEPTH, 1, 0)) begin errors++; $display("FAIL ovf_status: got %h expected %h", d, status_word(DEPTH, 1, 0)); end
        wr(32'h4, 32'h8);
        rd(32'h4, d);
        checks++; if (d !== status_word(DEPTH, 0, 0)) begin errors++; $display("FAIL ovf_clear: got %h expected %h", d, status_word(DEPTH, 0, 0)); end
        wr(32'h0, 32'h1);
        // This push shares its edge with the first pop of a full FIFO and is kept.
        b = 8'($urandom);
        wr(32'hC, {24'h0, b});
        q.push_back(b);
        rd(32'h4, d);
        checks++; if (d !== status_word(DEPTH, 0, 1)) begin errors++; $display("FAIL push_pop_full: got %h expected %h", d, status_word(DEPTH, 0, 1)); end
        for (int i = 0; i < (DEPTH + 1) * 41; i++) begin
            k = i / 41; t = i % 41;
            e = (t < 40) ? line_at(q[k], 4, t, 0, 0) : 1'b1;
            checks++; if (tx !== e) begin errors++; $display("FAIL fifo_order k=%0d t=%0d: got %b expected %b", k, t, tx, e); end
            step();
        end
        rd(32'h4, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL drained_status: got %h expected 4", d); end
        wr(32'h0, 32'h0);
    endtask

    task automatic test_irq();
        logic e;
        wr(32'h8, 32'd2);
        wr(32'h0, 32'h3);
        step();
        step();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_idle: got %b expected 1", irq); end
        wr(32'hC, 32'h3C);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_push_drop: got %b expected 0", irq); end
        for (int i = 1; i <= 22; i++) begin
            step();
            e = (i >= 22);
            checks++; if (irq !== e) begin errors++; $display("FAIL irq_frame i=%0d: got %b expected %b", i, irq, e); end
        end
        wr(32'h0, 32'h0);
    endtask

    task automatic test_disable_reset();
        logic [31:0] d;
        logic [7:0]  b0, b1;
        logic        e;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        wr(32'h8, 32'd4);
        wr(32'h0, 32'h1);
        wr(32'hC, {24'h0, b0});
        wr(32'hC, {24'h0, b1});
        for (int t = 0; t < 60; t++) begin
            e = (t < 40) ? line_at(b0, 4, t, 0, 0) : 1'b1;
            checks++; if (tx !== e) begin errors++; $display("FAIL disable_line t=%0d: got %b expected %b", t, tx, e); end
            if (t == 15) begin req = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'h0; end
            step();
            req = 1'b0; we = 1'b0;
        end
        rd(32'h4, d);
        checks++; if (d !== status_word(1, 0, 0)) begin errors++; $display("FAIL disable_status: got %h expected %h", d, status_word(1, 0, 0)); end
        wr(32'h0, 32'h1);
        step();
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL resume_start: got %b expected 0", tx); end
        rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b expected 1", tx); end
        step();
        rst = 1'b0;
        step();
        rd(32'h4, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL reset_fifo_empty: got %h expected 4", d); end
        rd(32'h8, d);
        checks++; if (d !== 32'h1B2) begin errors++; $display("FAIL reset_baud_again: got %h expected 1b2", d); end
    endtask

    task automatic test_baud_zero();
        logic [31:0] d;
        logic [7:0]  b;
        b = 8'($urandom);
        wr(32'h8, 32'h0);
        rd(32'h8, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL baud_zero: got %h expected 1", d); end
        wr(32'h0, 32'h1);
        wr(32'hC, {24'h0, b});
        for (int t = 0; t < 11; t++) begin
            step();
            checks++; if (tx !== line_at(b, 1, t, 0, 0)) begin errors++; $display("FAIL baud1_line t=%0d: got %b expected %b", t, tx, line_at(b, 1, t, 0, 0)); end
        end
        wr(32'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0]  q[$];
        logic [7:0]  b;
        int          bd, n, per, k, t;
        logic        e;
        for (int it = 0; it < 4; it++) begin
            bd = $urandom_range(1, 5);
            n = $urandom_range(1, 4);
            per = 10 * bd + 1;
            q.delete();
            wr(32'h0, 32'h0);
            wr(32'h8, bd);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                wr(32'hC, {24'h0, b});
                q.push_back(b);
            end
            rd(32'h4, d);
            checks++; if (d !== status_word(n, 0, 0)) begin errors++; $display("FAIL b2b_count it=%0d: got %h expected %h", it, d, status_word(n, 0, 0)); end
            wr(32'h0, 32'h1);
            for (int i = 0; i < n * per; i++) begin
                step();
                k = i / per; t = i % per;
                e = (t < per - 1) ? line_at(q[k], bd, t, 0, 0) : 1'b1;
                checks++; if (tx !== e) begin errors++; $display("FAIL b2b_line it=%0d k=%0d t=%0d: got %b expected %b", it, k, t, tx, e); end
            end
        end
        wr(32'h0, 32'h0);
    endtask

`ifdef RIB_UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] b;
        wr(32'h8, 32'd4);
        wr(32'h0, 32'hD);
        wr(32'hC, 32'h07);
        for (int t = 0; t < 45; t++) begin
            step();
            checks++; if (tx !== line_at(8'h07, 4, t, 1, 1)) begin errors++; $display("FAIL odd_parity t=%0d: got %b expected %b", t, tx, line_at(8'h07, 4, t, 1, 1)); end
        end
        b = 8'($urandom);
        wr(32'h0, 32'h5);
        wr(32'hC, {24'h0, b});
        for (int t = 0; t < 45; t++) begin
            step();
            checks++; if (tx !== line_at(b, 4, t, 1, 0)) begin errors++; $display("FAIL even_parity t=%0d: got %b expected %b", t, tx, line_at(b, 4, t, 1, 0)); end
        end
        wr(32'h0, 32'h0);
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_irq();
        test_disable_reset();
        test_baud_zero();
        test_back_to_back();
`ifdef RIB_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
